// File: rtl/apb_pkg.sv
// Shared types for the APB4 master bridge: FSM states, the captured request and bus widths.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = APB_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb_mst_state_e;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic                  write;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] strb;
   } apb_req_t;

   // Loads never present byte strobes on the bus.
   function automatic apb_req_t apb_req_pack(
      input logic [APB_ADDR_W-1:0] addr,
      input logic                  write,
      input logic [APB_DATA_W-1:0] wdata,
      input logic [APB_STRB_W-1:0] strb
   );
      apb_req_t req;
      req.addr  = addr;
      req.write = write;
      req.wdata = wdata;
      req.strb  = write ? strb : '0;
      return req;
   endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// CPU valid/ready to APB4 requester, one outstanding transfer, fully registered outputs.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states and expose timeout_seen.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_write,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   m_paddr,
   output logic                m_pwrite,
   output logic [DATA_W-1:0]   m_pwdata,
   output logic [DATA_W/8-1:0] m_pstrb,
   output logic                m_psel,
   output logic                m_penable,
   input  logic                m_pready,
   input  logic [DATA_W-1:0]   m_prdata,
`ifdef APB_MASTER_TIMEOUT_EN
   output logic                timeout_seen,
`endif
   input  logic                m_pslverr
);

   // The request register is the packed package struct, so widths must match it.
   if (ADDR_W != APB_ADDR_W || DATA_W != APB_DATA_W || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("apb_master_bridge: unsupported parameter set");
   end

   apb_mst_state_e         state_q, state_d;
   apb_req_t               req_q, req_d;
   logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   req_ready_q, rsp_valid_q, psel_q, penable_q;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic                   timeout_seen_q, timeout_seen_d;
`endif

   // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_d     = wait_cnt_q;
      timeout_seen_d = timeout_seen_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_d   = apb_req_pack(req_addr, req_write, req_wdata, req_wstrb);
               state_d = ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            // A completing PREADY wins over a timeout landing in the same cycle.
            if (m_pready) begin
               rsp_rdata_d = (req_q.write || m_pslverr) ? '0 : m_prdata;
               rsp_err_d   = m_pslverr;
               state_d     = ST_RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_rdata_d    = '0;
               rsp_err_d      = 1'b1;
               timeout_seen_d = 1'b1;
               state_d        = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt_q     <= '0;
         timeout_seen_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         // Handshake and bus controls are decoded from the next state so they leave a flop.
         req_ready_q <= (state_d == ST_IDLE);
         rsp_valid_q <= (state_d == ST_RESP);
         psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
         penable_q   <= (state_d == ST_ACCESS);
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt_q     <= wait_cnt_d;
         timeout_seen_q <= timeout_seen_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign m_paddr   = req_q.addr;
   assign m_pwrite  = req_q.write;
   assign m_pwdata  = req_q.wdata;
   assign m_pstrb   = req_q.strb;
   assign m_psel    = psel_q;
   assign m_penable = penable_q;
`ifdef APB_MASTER_TIMEOUT_EN
   assign timeout_seen = timeout_seen_q;
`endif

endmodule
